// File: rtl/rvh_noc_pkg.sv
// Shared NoC router types: VC buffer entry layout and the VC id width helper.
package rvh_noc_pkg;

   localparam int unsigned QoS_Value_Width  = 4;
   localparam int unsigned FlitPayloadWidth = 256;

   typedef logic [FlitPayloadWidth-1:0] flit_payload_t;
   typedef logic [QoS_Value_Width-1:0]  qos_value_t;

   // QoS sits in the upper bits so a head's priority is a plain slice of the entry.
   typedef struct packed {
      qos_value_t    qos;
      flit_payload_t payload;
   } vc_buf_entry_t;

   function automatic int unsigned vc_id_width(input int unsigned vc_num);
      return (vc_num > 1) ? $clog2(vc_num) : 1;
   endfunction

endpackage

// File: rtl/rvh_noc_vc_fifo.sv
// Single-VC circular FIFO; storage is not reset, pointers and count are.
module rvh_noc_vc_fifo #(
   parameter int unsigned DEPTH   = 2,
   parameter int unsigned ENTRY_W = 8,
   localparam int unsigned PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int unsigned CNT_W  = $clog2(DEPTH + 1)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               push,
   input  logic               pop,
   input  logic [ENTRY_W-1:0] wdata,
   output logic [ENTRY_W-1:0] head,
   output logic [CNT_W-1:0]   count,
   output logic               empty
);

   logic [ENTRY_W-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0]   rd_ptr_q, wr_ptr_q;
   logic [CNT_W-1:0]   cnt_q;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= wdata;
   end

   // The parent never pushes when full nor pops when empty.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
         if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
         if (push && !pop)      cnt_q <= cnt_q + 1'b1;
         else if (pop && !push) cnt_q <= cnt_q - 1'b1;
      end
   end

   assign head  = mem_q[rd_ptr_q];
   assign count = cnt_q;
   assign empty = (cnt_q == '0);

endmodule

// File: rtl/rvh_noc_qos_vc_buffer.sv
// Per-input-port VC buffer: VC_NUM credit-controlled FIFOs, QoS + round-robin head select.
// Define RVH_NOC_QOS_AGING_EN to add per-VC head aging above QoS in the priority.
module rvh_noc_qos_vc_buffer
   import rvh_noc_pkg::*;
#(
   parameter int unsigned VC_NUM    = 6,
   parameter int unsigned VC_DEPTH  = 2,
   parameter int unsigned PAYLOAD_W = 256,
   parameter int unsigned QOS_W     = 4,
   parameter int unsigned AGE_W     = 4,
   localparam int unsigned VC_ID_W  = vc_id_width(VC_NUM),
   localparam int unsigned CNT_W    = $clog2(VC_DEPTH + 1)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 rx_flit_vld_i,
   input  logic [VC_ID_W-1:0]   rx_flit_vc_id_i,
   input  logic [QOS_W-1:0]     rx_flit_qos_i,
   input  logic [PAYLOAD_W-1:0] rx_flit_payload_i,
   output logic                 rx_lcrd_v_o,
   output logic [VC_ID_W-1:0]   rx_lcrd_id_o,
   output logic                 tx_flit_vld_o,
   input  logic                 tx_flit_rdy_i,
   output logic [VC_ID_W-1:0]   tx_flit_vc_id_o,
   output logic [QOS_W-1:0]     tx_flit_qos_o,
   output logic [PAYLOAD_W-1:0] tx_flit_payload_o,
   input  logic [VC_NUM-1:0]    vc_block_i,
   output logic [VC_NUM-1:0]    vc_empty_o,
   output logic                 ovf_err_o
);

   localparam int unsigned ENTRY_W = QOS_W + PAYLOAD_W;

   if (VC_NUM == 0 || VC_DEPTH == 0 || AGE_W == 0) begin : g_bad_cfg
      $error("rvh_noc_qos_vc_buffer: VC_NUM, VC_DEPTH and AGE_W must be >= 1");
   end

   logic [VC_NUM-1:0]  push, pop, empty, elig;
   logic [ENTRY_W-1:0] head [VC_NUM];
   logic [CNT_W-1:0]   cnt  [VC_NUM];
   logic               in_range, full_hit, found, fire;
   logic [VC_ID_W-1:0] win, rr_ptr_q, lcrd_id_q;
   logic [ENTRY_W-1:0] win_entry;
   logic               lcrd_v_q, ovf_q;

   // Full is judged on the pre-pop count, so a write to a full VC drops even if it pops now.
   always_comb begin : write_decode
      push     = '0;
      in_range = 1'b0;
      full_hit = 1'b0;
      for (int unsigned v = 0; v < VC_NUM; v++) begin
         if (rx_flit_vc_id_i == VC_ID_W'(v)) begin
            in_range = 1'b1;
            if (cnt[v] == CNT_W'(VC_DEPTH)) full_hit = 1'b1;
            else                            push[v]  = rx_flit_vld_i;
         end
      end
   end

   for (genvar g = 0; g < VC_NUM; g++) begin : g_vc
      rvh_noc_vc_fifo #(
         .DEPTH   (VC_DEPTH),
         .ENTRY_W (ENTRY_W)
      ) u_fifo (
         .clk   (clk),
         .rst   (rst),
         .push  (push[g]),
         .pop   (pop[g]),
         .wdata ({rx_flit_qos_i, rx_flit_payload_i}),
         .head  (head[g]),
         .count (cnt[g]),
         .empty (empty[g])
      );
   end

   assign elig = ~empty & ~vc_block_i;

`ifdef RVH_NOC_QOS_AGING_EN
   localparam int unsigned PRIO_W = QOS_W + 1;
   logic [AGE_W-1:0] age_q [VC_NUM];

   // Only the fired winner pops, so "eligible and not popped" means "lost this cycle".
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int unsigned v = 0; v < VC_NUM; v++) age_q[v] <= '0;
      end else begin
         for (int unsigned v = 0; v < VC_NUM; v++) begin
            if (pop[v])                          age_q[v] <= '0;
            else if (elig[v] && age_q[v] != '1)  age_q[v] <= age_q[v] + 1'b1;
         end
      end
   end

   logic [PRIO_W-1:0] prio [VC_NUM];
   always_comb begin
      for (int unsigned v = 0; v < VC_NUM; v++) begin
         prio[v] = {&age_q[v], head[v][ENTRY_W-1 -: QOS_W]};
      end
   end
`else
   localparam int unsigned PRIO_W = QOS_W;

   logic [PRIO_W-1:0] prio [VC_NUM];
   always_comb begin
      for (int unsigned v = 0; v < VC_NUM; v++) prio[v] = head[v][ENTRY_W-1 -: QOS_W];
   end
`endif

   // Scan from rr_ptr+1 upward; strict '>' keeps the earliest VC in scan order on ties.
   always_comb begin : select
      int unsigned       idx;
      logic [VC_ID_W-1:0] sel;
      logic [PRIO_W-1:0]  best;
      found = 1'b0;
      win   = '0;
      best  = '0;
      for (int unsigned i = 0; i < VC_NUM; i++) begin
         idx = (32'(rr_ptr_q) + 1 + i) % VC_NUM;
         sel = VC_ID_W'(idx);
         if (elig[sel] && (!found || prio[sel] > best)) begin
            found = 1'b1;
            win   = sel;
            best  = prio[sel];
         end
      end
      win_entry = found ? head[win] : '0;
      fire      = found & tx_flit_rdy_i;
      pop       = '0;
      pop[win]  = fire;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rr_ptr_q  <= VC_ID_W'(VC_NUM - 1);
         lcrd_v_q  <= 1'b0;
         lcrd_id_q <= '0;
         ovf_q     <= 1'b0;
      end else begin
         lcrd_v_q <= fire;
         if (fire) begin
            rr_ptr_q  <= win;
            lcrd_id_q <= win;
         end
         if (rx_flit_vld_i && (!in_range || full_hit)) ovf_q <= 1'b1;
      end
   end

   assign tx_flit_vld_o     = found;
   assign tx_flit_vc_id_o   = win;
   assign tx_flit_qos_o     = win_entry[ENTRY_W-1 -: QOS_W];
   assign tx_flit_payload_o = win_entry[PAYLOAD_W-1:0];
   assign rx_lcrd_v_o       = lcrd_v_q;
   assign rx_lcrd_id_o      = lcrd_id_q;
   assign vc_empty_o        = empty;
   assign ovf_err_o         = ovf_q;

endmodule

// File: tb/tb_rvh_noc_qos_vc_buffer.sv
// Bench for rvh_noc_qos_vc_buffer: selection table plus scoreboarded output/credit sequences.
module tb_rvh_noc_qos_vc_buffer;

   localparam int unsigned VC_NUM    = 6;
   localparam int unsigned VC_DEPTH  = 2;
   localparam int unsigned PAYLOAD_W = 32;
   localparam int unsigned QOS_W     = 4;
   localparam int unsigned AGE_W     = 2;
   localparam int unsigned VC_ID_W   = 3;

   logic                 clk = 1'b0;
   logic                 rst = 1'b1;
   logic                 vld = 1'b0;
   logic [VC_ID_W-1:0]   vcid = '0;
   logic [QOS_W-1:0]     qos = '0;
   logic [PAYLOAD_W-1:0] payload = '0;
   logic                 lcrd_v;
   logic [VC_ID_W-1:0]   lcrd_id;
   logic                 tx_vld;
   logic                 rdy = 1'b0;
   logic [VC_ID_W-1:0]   tx_vc;
   logic [QOS_W-1:0]     tx_qos;
   logic [PAYLOAD_W-1:0] tx_pl;
   logic [VC_NUM-1:0]    block = '0;
   logic [VC_NUM-1:0]    vc_empty;
   logic                 ovf;

   rvh_noc_qos_vc_buffer #(
      .VC_NUM    (VC_NUM),
      .VC_DEPTH  (VC_DEPTH),
      .PAYLOAD_W (PAYLOAD_W),
      .QOS_W     (QOS_W),
      .AGE_W     (AGE_W)
   ) dut (
      .clk               (clk),
      .rst               (rst),
      .rx_flit_vld_i     (vld),
      .rx_flit_vc_id_i   (vcid),
      .rx_flit_qos_i     (qos),
      .rx_flit_payload_i (payload),
      .rx_lcrd_v_o       (lcrd_v),
      .rx_lcrd_id_o      (lcrd_id),
      .tx_flit_vld_o     (tx_vld),
      .tx_flit_rdy_i     (rdy),
      .tx_flit_vc_id_o   (tx_vc),
      .tx_flit_qos_o     (tx_qos),
      .tx_flit_payload_o (tx_pl),
      .vc_block_i        (block),
      .vc_empty_o        (vc_empty),
      .ovf_err_o         (ovf)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [VC_ID_W-1:0]   vc;
      logic [QOS_W-1:0]     qos;
      logic [PAYLOAD_W-1:0] payload;
   } flit_t;

   typedef struct {
      logic              wr;
      logic [2:0]        vc;
      logic [3:0]        qos;
      logic [5:0]        block;
      logic              exp_vld;
      logic [2:0]        exp_vc;
      logic [3:0]        exp_qos;
      logic [5:0]        exp_empty;
      logic              exp_ovf;
   } row_t;

   flit_t              exp_q[$];
   row_t               rows[7];
   int                 n_tests = 0;
   int                 n_fail  = 0;
   logic               cred_pend = 1'b0;
   logic [VC_ID_W-1:0] cred_id = '0;

   function automatic logic [31:0] pl(input logic [2:0] v, input logic [3:0] q,
                                      input logic [7:0] tag);
      return {8'hA5, tag, 5'd0, v, 4'd0, q};
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, required %0h", name, act, exp);
      end
   endtask

   // One clock: sample/score outputs on the falling edge, then advance past the rising edge.
   task automatic step();
      flit_t e;
      logic  nxt_pend;
      @(negedge clk);
      if (!rst) begin
         chk("credit_v", {63'd0, lcrd_v}, {63'd0, cred_pend});
         if (cred_pend) chk("credit_id", 64'(lcrd_id), 64'(cred_id));
         nxt_pend = 1'b0;
         if (tx_vld && rdy) begin
            if (exp_q.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL unexpected_fire: got vc %0d payload %0h, required no output",
                        tx_vc, tx_pl);
            end else begin
               e = exp_q.pop_front();
               chk("tx_vc", 64'(tx_vc), 64'(e.vc));
               chk("tx_qos", 64'(tx_qos), 64'(e.qos));
               chk("tx_payload", 64'(tx_pl), 64'(e.payload));
               nxt_pend = 1'b1;
               cred_id  = e.vc;
            end
         end
         cred_pend = nxt_pend;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [2:0] v, input logic [3:0] q, input logic [31:0] p);
      vld     = 1'b1;
      vcid    = v;
      qos     = q;
      payload = p;
      step();
      vld = 1'b0;
   endtask

   task automatic push_exp(input logic [2:0] v, input logic [3:0] q, input logic [31:0] p);
      flit_t f;
      f.vc      = v;
      f.qos     = q;
      f.payload = p;
      exp_q.push_back(f);
   endtask

   task automatic drain(input string name, input int cycles);
      rdy = 1'b1;
      repeat (cycles) step();
      rdy = 1'b0;
      chk(name, 64'(exp_q.size()), 64'd0);
   endtask

   task automatic do_reset();
      rst     = 1'b1;
      vld     = 1'b0;
      rdy     = 1'b0;
      block   = '0;
      vcid    = '0;
      qos     = '0;
      payload = '0;
      repeat (2) @(posedge clk);
      #1;
      rst       = 1'b0;
      cred_pend = 1'b0;
      cred_id   = '0;
   endtask

   initial begin
      rows[0] = '{1'b1, 3'd2, 4'd3, 6'b000000, 1'b1, 3'd2, 4'd3, 6'b111011, 1'b0};
      rows[1] = '{1'b1, 3'd1, 4'd5, 6'b000000, 1'b1, 3'd1, 4'd5, 6'b111001, 1'b0};
      rows[2] = '{1'b1, 3'd4, 4'd9, 6'b000000, 1'b1, 3'd4, 4'd9, 6'b101001, 1'b0};
      rows[3] = '{1'b0, 3'd0, 4'd0, 6'b010000, 1'b1, 3'd1, 4'd5, 6'b101001, 1'b0};
      rows[4] = '{1'b0, 3'd0, 4'd0, 6'b010010, 1'b1, 3'd2, 4'd3, 6'b101001, 1'b0};
      rows[5] = '{1'b0, 3'd0, 4'd0, 6'b010110, 1'b0, 3'd0, 4'd0, 6'b101001, 1'b0};
      rows[6] = '{1'b1, 3'd7, 4'd1, 6'b000000, 1'b1, 3'd4, 4'd9, 6'b101001, 1'b1};

      // Reset state
      do_reset();
      chk("rst_lcrd_v", {63'd0, lcrd_v}, 64'd0);
      chk("rst_lcrd_id", 64'(lcrd_id), 64'd0);
      chk("rst_ovf", {63'd0, ovf}, 64'd0);
      chk("rst_empty", 64'(vc_empty), 64'h3f);
      chk("rst_tx_vld", {63'd0, tx_vld}, 64'd0);
      chk("rst_tx_vc", 64'(tx_vc), 64'd0);
      chk("rst_tx_qos", 64'(tx_qos), 64'd0);
      chk("rst_tx_pl", 64'(tx_pl), 64'd0);

      // Selection table, no pops
      for (int r = 0; r < 7; r++) begin
         vld     = rows[r].wr;
         vcid    = rows[r].vc;
         qos     = rows[r].qos;
         payload = pl(rows[r].vc, rows[r].qos, 8'h00);
         block   = '0;
         step();
         vld   = 1'b0;
         block = rows[r].block;
         #1;
         chk($sformatf("row%0d_vld", r), {63'd0, tx_vld}, {63'd0, rows[r].exp_vld});
         chk($sformatf("row%0d_vc", r), 64'(tx_vc), 64'(rows[r].exp_vc));
         chk($sformatf("row%0d_qos", r), 64'(tx_qos), 64'(rows[r].exp_qos));
         chk($sformatf("row%0d_pl", r), 64'(tx_pl),
             rows[r].exp_vld ? 64'(pl(rows[r].exp_vc, rows[r].exp_qos, 8'h00)) : 64'd0);
         chk($sformatf("row%0d_empty", r), 64'(vc_empty), 64'(rows[r].exp_empty));
         chk($sformatf("row%0d_ovf", r), {63'd0, ovf}, {63'd0, rows[r].exp_ovf});
      end

      // Single flit: write-to-head and fire-to-credit latency
      do_reset();
      push_exp(3'd2, 4'd3, pl(3'd2, 4'd3, 8'h01));
      wr(3'd2, 4'd3, pl(3'd2, 4'd3, 8'h01));
      chk("single_vld", {63'd0, tx_vld}, 64'd1);
      rdy = 1'b1;
      step();
      rdy = 1'b0;
      step();
      chk("single_empty", 64'(vc_empty), 64'h3f);
      chk("single_drain", 64'(exp_q.size()), 64'd0);

      // Overflow on full VC, then out-of-range VC id
      do_reset();
      push_exp(3'd0, 4'd1, pl(3'd0, 4'd1, 8'h11));
      push_exp(3'd0, 4'd1, pl(3'd0, 4'd1, 8'h12));
      wr(3'd0, 4'd1, pl(3'd0, 4'd1, 8'h11));
      wr(3'd0, 4'd1, pl(3'd0, 4'd1, 8'h12));
      chk("ovf_before_third", {63'd0, ovf}, 64'd0);
      wr(3'd0, 4'd1, pl(3'd0, 4'd1, 8'h13));
      chk("ovf_full", {63'd0, ovf}, 64'd1);
      drain("ovf_drain", 6);
      chk("ovf_sticky", {63'd0, ovf}, 64'd1);
      do_reset();
      chk("ovf_cleared", {63'd0, ovf}, 64'd0);
      wr(3'd7, 4'd2, pl(3'd7, 4'd2, 8'h14));
      chk("ovf_bad_id", {63'd0, ovf}, 64'd1);
      chk("bad_id_dropped", {63'd0, tx_vld}, 64'd0);

      // QoS order
      do_reset();
      wr(3'd1, 4'd5, pl(3'd1, 4'd5, 8'h21));
      wr(3'd4, 4'd9, pl(3'd4, 4'd9, 8'h22));
      push_exp(3'd4, 4'd9, pl(3'd4, 4'd9, 8'h22));
      push_exp(3'd1, 4'd5, pl(3'd1, 4'd5, 8'h21));
      drain("qos_drain", 5);

      // Round-robin on equal QoS
      do_reset();
      wr(3'd0, 4'd2, pl(3'd0, 4'd2, 8'h31));
      wr(3'd3, 4'd2, pl(3'd3, 4'd2, 8'h32));
      wr(3'd0, 4'd2, pl(3'd0, 4'd2, 8'h33));
      wr(3'd3, 4'd2, pl(3'd3, 4'd2, 8'h34));
      push_exp(3'd0, 4'd2, pl(3'd0, 4'd2, 8'h31));
      push_exp(3'd3, 4'd2, pl(3'd3, 4'd2, 8'h32));
      push_exp(3'd0, 4'd2, pl(3'd0, 4'd2, 8'h33));
      push_exp(3'd3, 4'd2, pl(3'd3, 4'd2, 8'h34));
      drain("rr_drain", 7);

      // Block mask
      do_reset();
      wr(3'd4, 4'd9, pl(3'd4, 4'd9, 8'h41));
      wr(3'd1, 4'd5, pl(3'd1, 4'd5, 8'h42));
      push_exp(3'd1, 4'd5, pl(3'd1, 4'd5, 8'h42));
      push_exp(3'd4, 4'd9, pl(3'd4, 4'd9, 8'h41));
      block = 6'b010000;
      rdy   = 1'b1;
      step();
      block = '0;
      drain("block_drain", 4);

      // Aging: VC0 low QoS against a continuously refilled VC5
      do_reset();
      block = 6'b000001;
      wr(3'd0, 4'd1, pl(3'd0, 4'd1, 8'h50));
      wr(3'd5, 4'd8, pl(3'd5, 4'd8, 8'h60));
      block = '0;
      rdy   = 1'b1;
`ifdef RVH_NOC_QOS_AGING_EN
      for (int k = 0; k < 3; k++) push_exp(3'd5, 4'd8, pl(3'd5, 4'd8, 8'(8'h60 + k)));
      push_exp(3'd0, 4'd1, pl(3'd0, 4'd1, 8'h50));
      for (int k = 3; k < 5; k++) push_exp(3'd5, 4'd8, pl(3'd5, 4'd8, 8'(8'h60 + k)));
      for (int k = 1; k <= 4; k++) wr(3'd5, 4'd8, pl(3'd5, 4'd8, 8'(8'h60 + k)));
`else
      for (int k = 0; k < 9; k++) push_exp(3'd5, 4'd8, pl(3'd5, 4'd8, 8'(8'h60 + k)));
      push_exp(3'd0, 4'd1, pl(3'd0, 4'd1, 8'h50));
      for (int k = 1; k <= 8; k++) wr(3'd5, 4'd8, pl(3'd5, 4'd8, 8'(8'h60 + k)));
`endif
      drain("aging_drain", 6);
      chk("aging_no_ovf", {63'd0, ovf}, 64'd0);

      // Reset mid-operation drops the pending credit and flushes the VCs
      do_reset();
      push_exp(3'd3, 4'd4, pl(3'd3, 4'd4, 8'h71));
      wr(3'd3, 4'd4, pl(3'd3, 4'd4, 8'h71));
      wr(3'd2, 4'd1, pl(3'd2, 4'd1, 8'h72));
      block = 6'b000100;
      rdy   = 1'b1;
      step();
      chk("midrst_credit_before", {63'd0, lcrd_v}, 64'd1);
      rst = 1'b1;
      #1;
      chk("midrst_credit", {63'd0, lcrd_v}, 64'd0);
      chk("midrst_empty", 64'(vc_empty), 64'h3f);
      chk("midrst_tx_vld", {63'd0, tx_vld}, 64'd0);
      chk("midrst_drain", 64'(exp_q.size()), 64'd0);
      do_reset();
      step();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
